// File: rtl/player_hit_manager.sv
// player_hit_manager
//   Converts level-type collision flags into single-cycle life decrement /
//   increment pulses, owns the post-hit invulnerability window and the
//   sprite blink during it, and goes quiet once lives are exhausted.
//
// Ports
//   clk                 system clock
//   resetN              asynchronous active-low reset
//   startOfFrame        one-cycle pulse per video frame
//   OneSecPulse         one-cycle pulse per second
//   collision_explosion level, player overlaps an explosion
//   collision_enemy     level, player overlaps an enemy
//   collision_lifekit   level, player overlaps a life kit
//   lives[3:0]          current life count from the lives controller
//   lives_over          lives == 0, from the lives controller
//   decrement_life      one-cycle pulse: lose one life
//   increment_life      one-cycle pulse: gain one life
//   invulnerable        high while in INVULN
//   player_hide         sprite blank request (blink)
//   hits_taken[7:0]     saturating count of hits applied
//
// state      | meaning
// VULNERABLE | hits are taken, kits are accepted
// INVULN     | post-hit window, hits ignored, sprite blinks
// DEAD       | lives exhausted, no events until reset

module player_hit_manager #(
  parameter logic [3:0] INVULN_SECONDS = 4'd2,
  parameter logic [3:0] BLINK_FRAMES   = 4'd4,
  parameter logic [3:0] MAX_LIVES      = 4'd9
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       OneSecPulse,
  input  logic       collision_explosion,
  input  logic       collision_enemy,
  input  logic       collision_lifekit,
  input  logic [3:0] lives,
  input  logic       lives_over,
  output logic       decrement_life,
  output logic       increment_life,
  output logic       invulnerable,
  output logic       player_hide,
  output logic [7:0] hits_taken
);

  typedef enum logic [1:0] {
    VULNERABLE = 2'd0,
    INVULN     = 2'd1,
    DEAD       = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] sec_cnt_q, sec_cnt_d;
  logic [3:0] frame_cnt_q, frame_cnt_d;
  logic       kit_prev_q;
  logic       kit_pending_q, kit_pending_d;
  logic       dec_q, dec_d;
  logic       inc_q, inc_d;
  logic       invuln_q, invuln_d;
  logic       hide_q, hide_d;
  logic [7:0] hits_q, hits_d;

  logic hit;
  logic kit_rise;
  logic kit_ok;

  assign hit      = collision_explosion | collision_enemy;
  assign kit_rise = collision_lifekit & ~kit_prev_q;
  assign kit_ok   = (lives < MAX_LIVES);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= VULNERABLE;
      sec_cnt_q     <= 4'd0;
      frame_cnt_q   <= 4'd0;
      kit_prev_q    <= 1'b0;
      kit_pending_q <= 1'b0;
      dec_q         <= 1'b0;
      inc_q         <= 1'b0;
      invuln_q      <= 1'b0;
      hide_q        <= 1'b0;
      hits_q        <= 8'd0;
    end else begin
      state_q       <= state_d;
      sec_cnt_q     <= sec_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      kit_prev_q    <= collision_lifekit;
      kit_pending_q <= kit_pending_d;
      dec_q         <= dec_d;
      inc_q         <= inc_d;
      invuln_q      <= invuln_d;
      hide_q        <= hide_d;
      hits_q        <= hits_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    sec_cnt_d     = sec_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    kit_pending_d = kit_pending_q;
    dec_d         = 1'b0;
    inc_d         = 1'b0;
    invuln_d      = invuln_q;
    hide_d        = hide_q;
    hits_d        = hits_q;

    // A deferred kit is served first (lives re-checked now); otherwise a
    // fresh rise is served directly.
    if (state_q != DEAD) begin
      if (kit_pending_q) begin
        kit_pending_d = 1'b0;
        inc_d         = kit_ok;
      end else if (kit_rise) begin
        inc_d = kit_ok;
      end
    end

    unique case (state_q)
      VULNERABLE: begin
        invuln_d = 1'b0;
        hide_d   = 1'b0;
        if (hit) begin
          dec_d       = 1'b1;
          inc_d       = 1'b0;
          // A kit rise coinciding with the hit is deferred by one cycle so
          // the two pulses never overlap.
          kit_pending_d = kit_pending_q | kit_rise;
          state_d     = INVULN;
          sec_cnt_d   = INVULN_SECONDS;
          frame_cnt_d = 4'd0;
          invuln_d    = 1'b1;
          if (hits_q != 8'hFF) hits_d = hits_q + 8'd1;
        end
      end
      INVULN: begin
        if (startOfFrame) begin
          if (frame_cnt_q == BLINK_FRAMES - 4'd1) begin
            hide_d      = ~hide_q;
            frame_cnt_d = 4'd0;
          end else begin
            frame_cnt_d = frame_cnt_q + 4'd1;
          end
        end
        if (OneSecPulse && sec_cnt_q != 4'd0) sec_cnt_d = sec_cnt_q - 4'd1;
        // Leave when the counter is (about to be) zero; a zero-length window
        // also exits right away.
        if (sec_cnt_q == 4'd0 || (OneSecPulse && sec_cnt_q == 4'd1)) begin
          state_d  = VULNERABLE;
          invuln_d = 1'b0;
          hide_d   = 1'b0;
        end
      end
      DEAD: begin
        invuln_d      = 1'b0;
        hide_d        = 1'b0;
        kit_pending_d = 1'b0;
      end
      default: state_d = VULNERABLE;
    endcase

    // Exhausted lives override everything, including a same-cycle hit.
    if (lives_over) begin
      state_d       = DEAD;
      dec_d         = 1'b0;
      inc_d         = 1'b0;
      invuln_d      = 1'b0;
      hide_d        = 1'b0;
      kit_pending_d = 1'b0;
      hits_d        = hits_q;
    end
  end

  assign decrement_life = dec_q;
  assign increment_life = inc_q;
  assign invulnerable   = invuln_q;
  assign player_hide    = hide_q;
  assign hits_taken     = hits_q;

endmodule
